// File: rtl/spike_encoder.sv
// spike_encoder: converts a valid/ready stream of pixel intensities into
// temporally coded spike times (brighter pixel -> earlier spike). One frame of
// `NUM_SPIKES pixels is collected in a shadow buffer while the active buffer
// drives the spiking layer. The encoder also owns the gamma-cycle time base.
// Optional feature macro: SPIKE_ENC_THRESH_EN. When it is defined, pixels below
// THRESH produce no spike.
// Configuration requirements: `TIME_PERIOD == 2**`LOG_TIME_PERIOD and
// PIX_BITS >= `LOG_TIME_PERIOD.

`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module spike_encoder #(
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned THRESH   = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_l,
  input  logic                                       pix_valid,
  output logic                                       pix_ready,
  input  logic [PIX_BITS-1:0]                        pix_data,
  input  logic                                       pix_last,
  output logic [`LOG_TIME_PERIOD:0]                  time_val,
  output logic [`NUM_SPIKES-1:0][`LOG_TIME_PERIOD:0] spike_times,
  output logic                                       volley_start,
  output logic                                       busy,
  output logic                                       frame_err,
  output logic [15:0]                                frame_count
);

  localparam int unsigned N_SPK = `NUM_SPIKES;
  localparam int unsigned LTP   = `LOG_TIME_PERIOD;
  localparam int unsigned TP    = `TIME_PERIOD;
  localparam int unsigned ST_W  = LTP + 1;
  localparam int unsigned IDX_W = (N_SPK > 1) ? $clog2(N_SPK) : 1;

  localparam logic [ST_W-1:0]  NO_SPIKE = {1'b1, {LTP{1'b0}}};
  localparam logic [ST_W-1:0]  TV_LAST  = ST_W'(TP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPK - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                        state;
  logic [N_SPK-1:0][ST_W-1:0]    shadow;
  logic                          shadow_full;
  logic [IDX_W-1:0]              idx;
  logic [LTP-1:0]                pix_time;
  logic [ST_W-1:0]               pix_code;
  logic                          accept_c;
  logic                          load_c;

  // Spike time is the top LTP bits of the inverted intensity.
  assign pix_time = LTP'((~pix_data) >> (PIX_BITS - LTP));

`ifdef SPIKE_ENC_THRESH_EN
  // Dim pixels are suppressed entirely.
  assign pix_code = (32'(pix_data) < THRESH) ? NO_SPIKE : {1'b0, pix_time};
`else
  // Every pixel spikes; THRESH only matters with the threshold feature enabled.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign pix_code      = {1'b0, pix_time};
`endif

  assign pix_ready = ~shadow_full;
  assign accept_c  = pix_valid & ~shadow_full;

  // The shadow frame moves to active when the time base is at end-of-period.
  assign load_c = shadow_full & ((state == S_IDLE) | (time_val == TV_LAST));

  // Shadow fill with frame-length checking against pix_last.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      shadow      <= {N_SPK{NO_SPIKE}};
      shadow_full <= 1'b0;
      idx         <= '0;
      frame_err   <= 1'b0;
    end else begin
      if (load_c) begin
        shadow_full <= 1'b0;
      end
      if (accept_c) begin
        if (pix_last != (idx == IDX_LAST)) begin
          idx       <= '0;
          frame_err <= 1'b1;
        end else begin
          shadow[idx] <= pix_code;
          if (pix_last) begin
            idx         <= '0;
            shadow_full <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

  // Volley sequencer: time base, active buffer swap and volley bookkeeping.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= S_IDLE;
      time_val     <= TV_LAST;
      spike_times  <= {N_SPK{NO_SPIKE}};
      volley_start <= 1'b0;
      busy         <= 1'b0;
      frame_count  <= '0;
    end else begin
      volley_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_c) begin
            spike_times  <= shadow;
            time_val     <= '0;
            volley_start <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            busy         <= 1'b1;
            state        <= S_RUN;
          end else begin
            time_val    <= TV_LAST;
            spike_times <= {N_SPK{NO_SPIKE}};
            busy        <= 1'b0;
          end
        end
        S_RUN: begin
          if (time_val != TV_LAST) begin
            time_val <= time_val + ST_W'(1);
          end else if (load_c) begin
            spike_times  <= shadow;
            time_val     <= '0;
            volley_start <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            busy         <= 1'b1;
          end else begin
            spike_times <= {N_SPK{NO_SPIKE}};
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder. The driver pushes expected volleys
// (spike codes plus the cycle at which each volley must start) into a queue;
// the monitor checks every DUT output once per cycle against that schedule.

`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module tb_spike_encoder;

  localparam int N   = `NUM_SPIKES;
  localparam int LTP = `LOG_TIME_PERIOD;
  localparam int TP  = `TIME_PERIOD;
  localparam int PB  = 8;
  localparam int THR = 16;
  localparam int SW  = LTP + 1;

  typedef logic [N-1:0][SW-1:0] st_t;

  typedef struct {
    int codes[N];
    int fill;
    int start;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          pix_valid;
  logic          pix_ready;
  logic [PB-1:0] pix_data;
  logic          pix_last;
  logic [SW-1:0] time_val;
  st_t           spike_times;
  logic          volley_start;
  logic          busy;
  logic          frame_err;
  logic [15:0]   frame_count;

  spike_encoder #(.PIX_BITS(PB), .THRESH(THR)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .time_val     (time_val),
    .spike_times  (spike_times),
    .volley_start (volley_start),
    .busy         (busy),
    .frame_err    (frame_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     vectors     = 0;
  int     miscompares = 0;
  frame_t exp_q[$];
  frame_t act;
  int     cur[$];
  int     act_start  = -1000;
  int     last_start = -1000;
  int     err_edge   = 32'h7fffffff;
  int     exp_fc     = 0;
  bit     in_reset   = 1'b1;

  // Reference encoding straight from the intensity-to-time rule.
  function automatic int enc(int p);
`ifdef SPIKE_ENC_THRESH_EN
    if (p < THR) return 1 << LTP;
`endif
    return (((1 << PB) - 1) - p) >> (PB - LTP);
  endfunction

  function automatic st_t all_off();
    st_t v;
    for (int i = 0; i < N; i++) v[i] = SW'(1 << LTP);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Frame-level model: a complete frame starts one cycle after it fills, but
  // never before the previous volley's period has run out.
  function automatic void model_accept(int p, bit last, int e);
    frame_t f;
    cur.push_back(enc(p));
    if (last != (cur.size() == N)) begin
      if (err_edge > e) err_edge = e;
      cur.delete();
    end else if (last) begin
      for (int i = 0; i < N; i++) f.codes[i] = cur[i];
      f.fill  = e;
      f.start = (e + 1 > last_start + TP) ? e + 1 : last_start + TP;
      last_start = f.start;
      exp_q.push_back(f);
      cur.delete();
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur.delete();
    act_start  = -1000;
    last_start = -1000;
    err_edge   = 32'h7fffffff;
    exp_fc     = 0;
  endfunction

  task automatic send_pix(input int p, input bit last);
    int waited = 0;
    pix_valid = 1'b1;
    pix_data  = PB'(p);
    pix_last  = last;
    while (!pix_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!pix_ready) check("pix_ready_timeout", 64'(pix_ready), 64'(1));
    else model_accept(p, last, cyc + 1);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_frame(input int px[N], input int len, input int last_at, input int gap_max);
    for (int i = 0; i < len; i++) begin
      send_pix(px[i], i == last_at);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic mon_cycle();
    int  k = cyc;
    bit  exp_vs = 1'b0;
    bit  in_vol;
    bit  exp_rdy;
    int  exp_tv;
    st_t exp_st;
    if (exp_q.size() > 0 && exp_q[0].start == k) begin
      act       = exp_q.pop_front();
      act_start = k;
      exp_fc++;
      exp_vs    = 1'b1;
    end
    in_vol  = (k - act_start) < TP;
    exp_tv  = in_vol ? k - act_start : TP - 1;
    exp_rdy = !(exp_q.size() > 0 && exp_q[0].fill <= k);
    exp_st  = all_off();
    if (in_vol) for (int i = 0; i < N; i++) exp_st[i] = SW'(act.codes[i]);
    check("volley_start", 64'(volley_start), 64'(exp_vs));
    check("time_val",     64'(time_val),     64'(exp_tv));
    check("busy",         64'(busy),         64'(in_vol));
    check("spike_times",  64'(spike_times),  64'(exp_st));
    check("frame_count",  64'(frame_count),  64'(exp_fc));
    check("frame_err",    64'(frame_err),    64'(k >= err_edge));
    check("pix_ready",    64'(pix_ready),    64'(exp_rdy));
  endtask

  // Monitor: compares all outputs once per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) mon_cycle();
    end
  end

  // Stimulus.
  initial begin
    int px[N];
    int len;
    int last_at;
    int waited;

    rst_l     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_time_val",     64'(time_val),     64'(TP - 1));
    check("rst_spike_times",  64'(spike_times),  64'(all_off()));
    check("rst_volley_start", 64'(volley_start), 64'(0));
    check("rst_busy",         64'(busy),         64'(0));
    check("rst_frame_err",    64'(frame_err),    64'(0));
    check("rst_frame_count",  64'(frame_count),  64'(0));
    check("rst_pix_ready",    64'(pix_ready),    64'(1));
    rst_l    = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);

    // Single directed frame.
    px = '{255, 128, 64, 0};
    send_frame(px, N, N - 1, 0);
    repeat (12) @(negedge clk);

    // Three frames with pix_valid held high: back-to-back volleys and backpressure.
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < N; i++) px[i] = int'($urandom_range(0, 255));
      send_frame(px, N, N - 1, 0);
    end
    repeat (30) @(negedge clk);

    // Framing errors: early pix_last, then missing pix_last, then a good frame.
    for (int i = 0; i < N; i++) px[i] = int'($urandom_range(0, 255));
    send_frame(px, 2, 1, 0);
    send_frame(px, N, -1, 0);
    send_frame(px, N, N - 1, 0);
    repeat (12) @(negedge clk);

    // Threshold boundary pixels.
    px = '{15, 16, 200, 0};
    send_frame(px, N, N - 1, 0);
    repeat (12) @(negedge clk);

    // Random traffic with gaps and occasional framing errors.
    for (int fr = 0; fr < 40; fr++) begin
      for (int i = 0; i < N; i++) px[i] = int'($urandom_range(0, 255));
      len     = N;
      last_at = N - 1;
      if ($urandom_range(0, 99) < 15) begin
        if ($urandom_range(0, 1) == 0) begin
          len     = int'($urandom_range(1, N - 1));
          last_at = len - 1;
        end else begin
          last_at = -1;
        end
      end
      send_frame(px, len, last_at, int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a volley.
    px = '{10, 90, 170, 250};
    send_frame(px, N, N - 1, 0);
    waited = 0;
    while (!(busy && time_val == SW'(4)) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("reset_wait_tv4", 64'(time_val), 64'(4));
    #2;
    in_reset = 1'b1;
    rst_l    = 1'b0;
    #1;
    check("midrst_time_val",     64'(time_val),     64'(TP - 1));
    check("midrst_spike_times",  64'(spike_times),  64'(all_off()));
    check("midrst_volley_start", 64'(volley_start), 64'(0));
    check("midrst_busy",         64'(busy),         64'(0));
    check("midrst_frame_err",    64'(frame_err),    64'(0));
    check("midrst_frame_count",  64'(frame_count),  64'(0));
    check("midrst_pix_ready",    64'(pix_ready),    64'(1));
    model_reset();
    repeat (2) @(negedge clk);
    rst_l    = 1'b1;
    in_reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) px[i] = int'($urandom_range(0, 255));
    send_frame(px, N, N - 1, 0);
    repeat (15) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
